// File: rtl/th_ctrl_scan.sv
// Pixel threshold-calibration controller.
// Steps the discriminator threshold code from ScanLo upward. At each code it
// counts synchronised DiscriPul rising edges over a window of 2**WIN_LOG2
// enabled cycles. From the counts it extracts the baseline (BL, the code with
// the most hits) and the noise width (NW, the span of codes that had hits).
// It then drives TH = BL + TH_offset. Bypass hands DAC straight to TH.
//
// Start/done handshake: a scan is requested by a rising edge of ScanStart
// seen in IDLE or DONE with Bypass low; the level afterwards is ignored.
// ScanDone rises together with valid BL/NW/TH/NoHit. It stays high until the
// next scan starts or Bypass is asserted. There is no backpressure.
module th_ctrl_scan #(
  parameter int DAC_W    = 10,
  parameter int OFS_W    = 6,
  parameter int NW_W     = 4,
  parameter int WIN_LOG2 = 15,
  parameter int ZERO_RUN = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                DiscriPul,
  input  logic                Bypass,
  input  logic                CLKEn,
  input  logic                ScanStart,
  input  logic [DAC_W-1:0]    ScanLo,
  input  logic [DAC_W-1:0]    ScanHi,
  input  logic [DAC_W-1:0]    DAC,
  input  logic [OFS_W-1:0]    TH_offset,
  output logic                ScanDone,
  output logic                NoHit,
  output logic [DAC_W-1:0]    TH,
  output logic [DAC_W-1:0]    BL,
  output logic [NW_W-1:0]     NW,
  output logic [WIN_LOG2:0]   Acc,
  output logic [2:0]          StateOut
);

  localparam int ACC_W = WIN_LOG2 + 1;
  localparam int ZR_W  = (ZERO_RUN < 2) ? 1 : $clog2(ZERO_RUN + 1);
  localparam logic [ZR_W-1:0]  ZR_LIM = ZR_W'(ZERO_RUN);
  localparam logic [DAC_W:0]   NW_LIM = (DAC_W + 1)'((1 << NW_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_COUNT = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]          sync_q;     // [0],[1] synchroniser, [2] previous synced value
  logic                start_q;
  logic [DAC_W-1:0]    code;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [ACC_W-1:0]    hits;
  logic [ACC_W-1:0]    max_hits;
  logic [DAC_W-1:0]    lo_code;
  logic [DAC_W-1:0]    hi_code;
  logic                seen;
  logic [ZR_W-1:0]     zero_run;

  logic                pul_rise;
  logic                start_rise;
  logic                win_last;
  logic                hit_any;
  logic [DAC_W-1:0]    bl_nxt;
  logic [DAC_W-1:0]    lo_nxt;
  logic [DAC_W-1:0]    hi_nxt;
  logic                seen_nxt;
  logic [ZR_W-1:0]     zr_nxt;
  logic                stop;
  logic [DAC_W:0]      span;
  logic [NW_W-1:0]     nw_sat;
  logic [DAC_W:0]      th_sum;
  logic [DAC_W-1:0]    th_final;

  assign pul_rise   = sync_q[1] & ~sync_q[2];
  assign start_rise = ScanStart & ~start_q;
  assign win_last   = CLKEn && (win_cnt == '1);
  assign StateOut   = state;

  // Per-code evaluation results and the values committed on scan completion.
  always_comb begin
    hit_any  = (hits != '0);
    bl_nxt   = (hits > max_hits) ? code : BL;
    lo_nxt   = (hit_any && !seen) ? code : lo_code;
    hi_nxt   = hit_any ? code : hi_code;
    seen_nxt = seen | hit_any;
    zr_nxt   = zero_run;
    if (hit_any)
      zr_nxt = '0;
    else if (seen && (zero_run != '1))
      zr_nxt = zero_run + ZR_W'(1);
    stop     = (code >= ScanHi) || ((ZERO_RUN > 0) && (zr_nxt == ZR_LIM));
    span     = {1'b0, hi_nxt} - {1'b0, lo_nxt} + (DAC_W + 1)'(1);
    nw_sat   = (span > NW_LIM) ? NW_LIM[NW_W-1:0] : span[NW_W-1:0];
    th_sum   = {1'b0, bl_nxt} + {{(DAC_W + 1 - OFS_W){1'b0}}, TH_offset};
    th_final = th_sum[DAC_W] ? '1 : th_sum[DAC_W-1:0];
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; Bypass always wins and parks the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!Bypass && start_rise) state_nxt = S_INIT;
      S_INIT:  state_nxt = Bypass ? S_IDLE : S_COUNT;
      S_COUNT: begin
        if (Bypass)        state_nxt = S_IDLE;
        else if (win_last) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (Bypass)    state_nxt = S_IDLE;
        else if (stop) state_nxt = S_DONE;
        else           state_nxt = S_COUNT;
      end
      S_DONE: begin
        if (Bypass)          state_nxt = S_IDLE;
        else if (start_rise) state_nxt = S_INIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Input synchronisation of the discriminator and ScanStart edge history.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q  <= '0;
      start_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], DiscriPul};
      start_q <= ScanStart;
    end
  end

  // Scan bookkeeping: current code, window/hit counters, hit statistics.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      code     <= '0;
      win_cnt  <= '0;
      hits     <= '0;
      max_hits <= '0;
      lo_code  <= '0;
      hi_code  <= '0;
      seen     <= 1'b0;
      zero_run <= '0;
    end else begin
      case (state)
        S_INIT: begin
          code     <= ScanLo;
          win_cnt  <= '0;
          hits     <= '0;
          max_hits <= '0;
          lo_code  <= '0;
          hi_code  <= '0;
          seen     <= 1'b0;
          zero_run <= '0;
        end
        S_COUNT: begin
          if (!Bypass && CLKEn) begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (pul_rise && (hits != '1)) hits <= hits + ACC_W'(1);
          end
        end
        S_EVAL: begin
          if (!Bypass) begin
            if (hits > max_hits) max_hits <= hits;
            lo_code  <= lo_nxt;
            hi_code  <= hi_nxt;
            seen     <= seen_nxt;
            zero_run <= zr_nxt;
            if (!stop) begin
              code    <= code + DAC_W'(1);
              win_cnt <= '0;
              hits    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: BL, NW, Acc, ScanDone, NoHit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      BL       <= '0;
      NW       <= '0;
      Acc      <= '0;
      ScanDone <= 1'b0;
      NoHit    <= 1'b0;
    end else begin
      if (Bypass) ScanDone <= 1'b0;
      case (state)
        S_INIT: begin
          BL       <= '0;
          NW       <= '0;
          ScanDone <= 1'b0;
          NoHit    <= 1'b0;
        end
        S_EVAL: begin
          if (!Bypass) begin
            Acc <= hits;
            BL  <= bl_nxt;
            if (stop) begin
              NW       <= seen_nxt ? nw_sat : '0;
              NoHit    <= ~seen_nxt;
              ScanDone <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Threshold output: DAC in bypass, scan code while scanning, final value after.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      TH <= '0;
    end else if (Bypass) begin
      TH <= DAC;
    end else begin
      case (state)
        S_INIT: TH <= ScanLo;
        S_EVAL: TH <= stop ? th_final : (code + DAC_W'(1));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_th_ctrl_scan.sv
// Directed bench for th_ctrl_scan with a 16-cycle window and early stop after 2 empty codes.
module tb_th_ctrl_scan;

  localparam int DAC_W    = 10;
  localparam int OFS_W    = 6;
  localparam int NW_W     = 4;
  localparam int WIN_LOG2 = 4;
  localparam int ZERO_RUN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               discri = 1'b0;
  logic               bypass = 1'b0;
  logic               clk_en = 1'b1;
  logic               scan_start = 1'b0;
  logic [DAC_W-1:0]   scan_lo = '0;
  logic [DAC_W-1:0]   scan_hi = '0;
  logic [DAC_W-1:0]   dac = '0;
  logic [OFS_W-1:0]   th_offset = '0;
  logic               scan_done;
  logic               no_hit;
  logic [DAC_W-1:0]   th;
  logic [DAC_W-1:0]   bl;
  logic [NW_W-1:0]    nw;
  logic [WIN_LOG2:0]  acc;
  logic [2:0]         state_out;

  int errors = 0;
  int checks = 0;
  bit tog_en = 1'b0;
  int n_count;
  int n_eval;
  int nh;
  bit fin;

  th_ctrl_scan #(
    .DAC_W(DAC_W), .OFS_W(OFS_W), .NW_W(NW_W), .WIN_LOG2(WIN_LOG2), .ZERO_RUN(ZERO_RUN)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .DiscriPul(discri), .Bypass(bypass), .CLKEn(clk_en),
    .ScanStart(scan_start), .ScanLo(scan_lo), .ScanHi(scan_hi), .DAC(dac),
    .TH_offset(th_offset), .ScanDone(scan_done), .NoHit(no_hit), .TH(th), .BL(bl),
    .NW(nw), .Acc(acc), .StateOut(state_out)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle, optionally keeping DiscriPul toggling every cycle.
  task automatic step();
    @(negedge clk);
    if (tog_en) discri = ~discri;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    bit got;
    got = 1'b0;
    n_count = 0;
    n_eval = 0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (state_out == target) got = 1'b1;
      else begin
        if (state_out == ST_COUNT) n_count++;
        if (state_out == ST_EVAL) n_eval++;
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'(state_out), 32'(target));
  endtask

  function automatic int hits_for(input logic [DAC_W-1:0] c);
    case (c)
      10'd103: return 2;
      10'd104: return 8;
      10'd105: return 5;
      default: return 0;
    endcase
  endfunction

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_th", 32'(th), 0);
    chk("rst_bl", 32'(bl), 0);
    chk("rst_nw", 32'(nw), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_nohit", 32'(no_hit), 0);
    chk("rst_state", 32'(state_out), 32'(ST_IDLE));

    // 1: reset in the middle of COUNT
    scan_lo = 10'd5; scan_hi = 10'd9;
    start_scan();
    repeat (4) step();
    chk("t1_in_count", 32'(state_out), 32'(ST_COUNT));
    chk("t1_th_code", 32'(th), 5);
    rst_n = 1'b0;
    #1;
    chk("t1_th", 32'(th), 0);
    chk("t1_bl", 32'(bl), 0);
    chk("t1_state", 32'(state_out), 32'(ST_IDLE));
    chk("t1_done", 32'(scan_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2: bypass, one-cycle latency, ScanStart ignored
    bypass = 1'b1; dac = 10'h155;
    chk("t2_th_before", 32'(th), 0);
    step();
    chk("t2_th_bypass", 32'(th), 32'h155);
    start_scan();
    step();
    chk("t2_state", 32'(state_out), 32'(ST_IDLE));
    dac = 10'h2AA;
    step();
    chk("t2_th_follow", 32'(th), 32'h2AA);
    bypass = 1'b0;
    step();

    // 3: pulses 2/8/5 at codes 103/104/105, early stop after 107
    scan_lo = 10'd100; scan_hi = 10'd110; th_offset = 6'd10;
    start_scan();
    n_eval = 0;
    for (int k = 0; k < 400 && state_out != ST_DONE; k++) begin
      if (state_out == ST_EVAL) begin
        n_eval++;
        if (th == 10'd104) chk("t3_acc_c103", 32'(acc), 2);
        if (th == 10'd105) chk("t3_acc_c104", 32'(acc), 8);
        if (th == 10'd106) chk("t3_acc_c105", 32'(acc), 5);
        // Pulses for the next code start here so all of them land in its window.
        nh = hits_for(th + 10'd1);
        for (int p = 0; p < nh; p++) begin
          discri = 1'b1; @(negedge clk);
          discri = 1'b0; @(negedge clk);
        end
      end
      @(negedge clk);
    end
    chk("t3_state", 32'(state_out), 32'(ST_DONE));
    chk("t3_codes", 32'(n_eval), 8);
    chk("t3_bl", 32'(bl), 104);
    chk("t3_nw", 32'(nw), 3);
    chk("t3_acc", 32'(acc), 0);
    chk("t3_th", 32'(th), 114);
    chk("t3_done", 32'(scan_done), 1);
    chk("t3_nohit", 32'(no_hit), 0);

    // 4: continuous toggling at the top of the range, TH saturates
    scan_lo = 10'd1020; scan_hi = 10'd1023; th_offset = 6'd63;
    tog_en = 1'b1;
    repeat (6) step();
    start_scan();
    wait_state(ST_DONE, 400, "t4");
    tog_en = 1'b0; discri = 1'b0;
    chk("t4_codes", 32'(n_eval), 4);
    chk("t4_bl", 32'(bl), 1020);
    chk("t4_nw", 32'(nw), 4);
    chk("t4_th", 32'(th), 1023);
    chk("t4_acc", 32'(acc), 8);
    chk("t4_done", 32'(scan_done), 1);
    repeat (4) step();

    // Abort with Bypass during COUNT
    scan_lo = 10'd200; scan_hi = 10'd210; dac = 10'd77;
    start_scan();
    repeat (3) step();
    bypass = 1'b1;
    step();
    chk("ab_state", 32'(state_out), 32'(ST_IDLE));
    chk("ab_bl", 32'(bl), 0);
    chk("ab_nw", 32'(nw), 0);
    chk("ab_done", 32'(scan_done), 0);
    chk("ab_th", 32'(th), 77);
    bypass = 1'b0;
    step();

    // 5: no pulses at all
    scan_lo = 10'd0; scan_hi = 10'd3; th_offset = 6'd5;
    start_scan();
    wait_state(ST_DONE, 400, "t5");
    chk("t5_codes", 32'(n_eval), 4);
    chk("t5_nohit", 32'(no_hit), 1);
    chk("t5_bl", 32'(bl), 0);
    chk("t5_nw", 32'(nw), 0);
    chk("t5_th", 32'(th), 5);

    // ScanLo > ScanHi evaluates one code
    scan_lo = 10'd20; scan_hi = 10'd10; th_offset = 6'd7;
    start_scan();
    wait_state(ST_DONE, 200, "inv");
    chk("inv_codes", 32'(n_eval), 1);
    chk("inv_th", 32'(th), 7);
    chk("inv_nohit", 32'(no_hit), 1);

    // Bypass from DONE
    bypass = 1'b1; dac = 10'h0AB;
    step();
    chk("bd_state", 32'(state_out), 32'(ST_IDLE));
    chk("bd_done", 32'(scan_done), 0);
    chk("bd_th", 32'(th), 32'h0AB);
    bypass = 1'b0;
    step();

    // 6a: CLKEn 50%, every enabled cycle carries a synced edge
    scan_lo = 10'd50; scan_hi = 10'd50; th_offset = 6'd3;
    n_count = 0; fin = 1'b0;
    for (int i = 1; i < 200 && !fin; i++) begin
      if (i > 3 && state_out == ST_DONE) fin = 1'b1;
      else begin
        if (state_out == ST_COUNT) n_count++;
        scan_start = (i == 1);
        clk_en = ((i % 2) == 0);
        discri = ((i % 2) == 0);
        @(negedge clk);
      end
    end
    chk("t6a_state", 32'(state_out), 32'(ST_DONE));
    chk("t6a_window", 32'(n_count), 32);
    chk("t6a_acc", 32'(acc), 16);
    chk("t6a_bl", 32'(bl), 50);
    chk("t6a_th", 32'(th), 53);
    chk("t6a_nw", 32'(nw), 1);

    // 6b: same, but every synced edge falls on a CLKEn=0 cycle
    n_count = 0; fin = 1'b0;
    for (int i = 1; i < 200 && !fin; i++) begin
      if (i > 3 && state_out == ST_DONE) fin = 1'b1;
      else begin
        if (state_out == ST_COUNT) n_count++;
        scan_start = (i == 1);
        clk_en = ((i % 2) == 1);
        discri = ((i % 2) == 0);
        @(negedge clk);
      end
    end
    chk("t6b_state", 32'(state_out), 32'(ST_DONE));
    chk("t6b_window", 32'(n_count), 31);
    chk("t6b_acc", 32'(acc), 0);
    chk("t6b_nohit", 32'(no_hit), 1);
    chk("t6b_th", 32'(th), 3);
    clk_en = 1'b1; discri = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
